// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: funct3 codes,
// FSM states and access-size helpers.
package riscv_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_ILL = 3'b111;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } lsu_state_e;

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Address bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] align_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/riscv_lsu_ldext.sv
// Load data path: select the addressed lane of the memory doubleword and
// sign- or zero-extend it according to funct3.
module riscv_lsu_ldext
  import riscv_lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] dword_i,
  input  logic [2:0]      off_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] lane;

  always_comb begin
    lane   = dword_i >> {off_i, 3'b000};
    data_o = '0;
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){lane[7]}}, lane[7:0]};
      F3_LH:   data_o = {{(XLEN-16){lane[15]}}, lane[15:0]};
      F3_LW:   data_o = {{(XLEN-32){lane[31]}}, lane[31:0]};
      F3_LD:   data_o = lane;
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, lane[7:0]};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, lane[15:0]};
      F3_LWU:  data_o = {{(XLEN-32){1'b0}}, lane[31:0]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Memory-stage load/store unit with req/ack handshake and pipeline stall.
// Optional misaligned-access trap: define RISCV_LSU_MISALIGN_TRAP_EN.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DM_AW = 64
) (
  input  logic             i_riscv_lsu_clk,
  input  logic             i_riscv_lsu_rst,
  input  logic             i_riscv_lsu_valid,
  input  logic             i_riscv_lsu_we,
  input  logic [2:0]       i_riscv_lsu_funct3,
  input  logic [XLEN-1:0]  i_riscv_lsu_addr,
  input  logic [XLEN-1:0]  i_riscv_lsu_wdata,
  input  logic             i_riscv_lsu_flush,
  output logic             o_riscv_lsu_dm_req,
  output logic             o_riscv_lsu_dm_we,
  output logic [DM_AW-1:0] o_riscv_lsu_dm_addr,
  output logic [7:0]       o_riscv_lsu_dm_be,
  output logic [XLEN-1:0]  o_riscv_lsu_dm_wdata,
  input  logic             i_riscv_lsu_dm_ack,
  input  logic [XLEN-1:0]  i_riscv_lsu_dm_rdata,
  output logic             o_riscv_lsu_stall,
  output logic [XLEN-1:0]  o_riscv_lsu_rdata,
  output logic             o_riscv_lsu_done,
  output logic             o_riscv_lsu_misalign
);

  lsu_state_e      state_q;
  logic            req_q, dm_we_q, kill_q, done_q, misalign_q;
  logic [2:0]      f3_q, off_q;
  logic [DM_AW-1:0] addr_q;
  logic [7:0]      be_q;
  logic [XLEN-1:0] wdata_q, rdata_q;

  logic [1:0]      sz;
  logic [2:0]      off_d;
  logic [7:0]      be_d;
  logic [XLEN-1:0] wdata_d, ld_ext;
  logic            illegal, misaligned, start;

  assign sz      = i_riscv_lsu_funct3[1:0];
  assign illegal = (i_riscv_lsu_funct3 == F3_ILL);

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
  assign misaligned = |(i_riscv_lsu_addr[2:0] & align_mask(sz));
  assign off_d      = i_riscv_lsu_addr[2:0];
`else
  // Without the trap, misaligned addresses silently round down to the access size.
  assign misaligned = 1'b0;
  assign off_d      = i_riscv_lsu_addr[2:0] & ~align_mask(sz);
`endif

  assign start = i_riscv_lsu_valid & ~i_riscv_lsu_flush & ~illegal & ~misaligned;
  assign be_d  = size_mask(sz) << off_d;

  // Replicating the store value puts it in every naturally aligned lane; be selects one.
  always_comb begin
    case ({1'b0, sz})
      F3_SB:   wdata_d = {8{i_riscv_lsu_wdata[7:0]}};
      F3_SH:   wdata_d = {4{i_riscv_lsu_wdata[15:0]}};
      F3_SW:   wdata_d = {2{i_riscv_lsu_wdata[31:0]}};
      default: wdata_d = i_riscv_lsu_wdata;
    endcase
  end

  riscv_lsu_ldext #(.XLEN(XLEN)) u_ldext (
    .dword_i  (i_riscv_lsu_dm_rdata),
    .off_i    (off_q),
    .funct3_i (f3_q),
    .data_o   (ld_ext)
  );

  always_ff @(posedge i_riscv_lsu_clk) begin
    if (i_riscv_lsu_rst) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      dm_we_q    <= 1'b0;
      kill_q     <= 1'b0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_BUSY;
            req_q   <= 1'b1;
            dm_we_q <= i_riscv_lsu_we;
            kill_q  <= 1'b0;
            f3_q    <= i_riscv_lsu_funct3;
            off_q   <= off_d;
            addr_q  <= {i_riscv_lsu_addr[DM_AW-1:3], 3'b000};
            be_q    <= be_d;
            wdata_q <= wdata_d;
          end else if (i_riscv_lsu_valid && !i_riscv_lsu_flush && illegal) begin
            done_q <= 1'b1;
            if (!i_riscv_lsu_we) rdata_q <= '0;
          end else if (i_riscv_lsu_valid && !i_riscv_lsu_flush && misaligned) begin
            misalign_q <= 1'b1;
          end
        end
        S_BUSY: begin
          if (i_riscv_lsu_flush) kill_q <= 1'b1;
          if (i_riscv_lsu_dm_ack) begin
            req_q   <= 1'b0;
            dm_we_q <= 1'b0;
            kill_q  <= 1'b0;
            if (kill_q || i_riscv_lsu_flush) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              if (!dm_we_q) rdata_q <= ld_ext;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    case (state_q)
      S_IDLE:  o_riscv_lsu_stall = start;
      S_BUSY:  o_riscv_lsu_stall = 1'b1;
      default: o_riscv_lsu_stall = 1'b0;
    endcase
  end

  assign o_riscv_lsu_dm_req   = req_q;
  assign o_riscv_lsu_dm_we    = dm_we_q;
  assign o_riscv_lsu_dm_addr  = addr_q;
  assign o_riscv_lsu_dm_be    = be_q;
  assign o_riscv_lsu_dm_wdata = wdata_q;
  assign o_riscv_lsu_rdata    = rdata_q;
  assign o_riscv_lsu_done     = done_q;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
  assign o_riscv_lsu_misalign = misalign_q;
`else
  assign o_riscv_lsu_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: directed scenarios plus randomized
// back-to-back loads/stores checked against a byte-level reference model.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst, valid, we, flush, ack;
  logic [2:0]  f3;
  logic [63:0] addr, wdata, dm_rdata;
  logic        dm_req, dm_we, stall, done, misal;
  logic [63:0] dm_addr, dm_wdata, rdata;
  logic [7:0]  dm_be;

  always #5 clk = ~clk;

  riscv_lsu #(.XLEN(64), .DM_AW(64)) dut (
    .i_riscv_lsu_clk      (clk),
    .i_riscv_lsu_rst      (rst),
    .i_riscv_lsu_valid    (valid),
    .i_riscv_lsu_we       (we),
    .i_riscv_lsu_funct3   (f3),
    .i_riscv_lsu_addr     (addr),
    .i_riscv_lsu_wdata    (wdata),
    .i_riscv_lsu_flush    (flush),
    .o_riscv_lsu_dm_req   (dm_req),
    .o_riscv_lsu_dm_we    (dm_we),
    .o_riscv_lsu_dm_addr  (dm_addr),
    .o_riscv_lsu_dm_be    (dm_be),
    .o_riscv_lsu_dm_wdata (dm_wdata),
    .i_riscv_lsu_dm_ack   (ack),
    .i_riscv_lsu_dm_rdata (dm_rdata),
    .o_riscv_lsu_stall    (stall),
    .o_riscv_lsu_rdata    (rdata),
    .o_riscv_lsu_done     (done),
    .o_riscv_lsu_misalign (misal)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [63:0] m_rdata;

  int          ob_stall, ob_done, ob_mis, ob_busy;
  logic        ob_unstable, ob_we;
  logic [63:0] ob_addr, ob_wdata;
  logic [7:0]  ob_be;

  // Reference model: byte-granular view of access size, lane offset and extension.
  function automatic int unsigned m_size(input logic [2:0] op_f3);
    return 1 << op_f3[1:0];
  endfunction

  function automatic int unsigned m_off(input logic [2:0] op_f3, input logic [63:0] a);
    int unsigned n;
    n = m_size(op_f3);
    return (int'(a[2:0]) / n) * n;
  endfunction

  function automatic logic [63:0] m_load(input logic [2:0] op_f3, input logic [63:0] a,
                                         input logic [63:0] d);
    int unsigned n, off;
    logic [63:0] v;
    n = m_size(op_f3); off = m_off(op_f3, a); v = '0;
    for (int unsigned i = 0; i < n; i++) v[8*i +: 8] = d[8*(off+i) +: 8];
    if (!op_f3[2] && n < 8 && v[8*n-1])
      for (int unsigned i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] m_be(input logic [2:0] op_f3, input logic [63:0] a);
    logic [7:0] be;
    be = '0;
    for (int unsigned i = 0; i < m_size(op_f3); i++) be[m_off(op_f3, a) + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [63:0] m_lane_mask(input logic [2:0] op_f3, input logic [63:0] a);
    logic [63:0] m;
    m = '0;
    for (int unsigned i = 0; i < m_size(op_f3); i++) m[8*(m_off(op_f3, a)+i) +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [63:0] m_lane_data(input logic [2:0] op_f3, input logic [63:0] a,
                                              input logic [63:0] w);
    logic [63:0] v;
    v = '0;
    for (int unsigned i = 0; i < m_size(op_f3); i++) v[8*(m_off(op_f3, a)+i) +: 8] = w[8*i +: 8];
    return v;
  endfunction

  // Drives one op for ncyc cycles, acking on the ack_at-th request cycle; records observations.
  task automatic run_op(input logic op_we, input logic [2:0] op_f3, input logic [63:0] op_addr,
                        input logic [63:0] op_wdata, input logic [63:0] op_rdata,
                        input int ack_at, input int flush_at, input int ncyc);
    ob_stall = 0; ob_done = 0; ob_mis = 0; ob_busy = 0; ob_unstable = 1'b0;
    ob_we = 1'b0; ob_addr = '0; ob_wdata = '0; ob_be = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      valid = (c == 0); we = op_we; f3 = op_f3; addr = op_addr; wdata = op_wdata;
      ack = 1'b0; flush = 1'b0; dm_rdata = '0;
      if (dm_req) begin
        ob_busy++;
        if (ob_busy == 1) begin
          ob_we = dm_we; ob_addr = dm_addr; ob_wdata = dm_wdata; ob_be = dm_be;
        end else if ({ob_we, ob_addr, ob_wdata, ob_be} !== {dm_we, dm_addr, dm_wdata, dm_be}) begin
          ob_unstable = 1'b1;
        end
        if (ob_busy == ack_at) begin ack = 1'b1; dm_rdata = op_rdata; end
        if (ob_busy == flush_at) flush = 1'b1;
      end
      #1;
      if (stall) ob_stall++;
      if (done)  ob_done++;
      if (misal) ob_mis++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; valid = 1'b0; we = 1'b0; flush = 1'b0; ack = 1'b0;
    f3 = '0; addr = '0; wdata = '0; dm_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (dm_req !== 1'b0) $display("FAIL rst_req: got %b want 0", dm_req); else n_pass++;
    n_checks++; if ({dm_we, dm_addr, dm_be, dm_wdata} !== '0) $display("FAIL rst_dm: got we=%b a=%h be=%h wd=%h want 0", dm_we, dm_addr, dm_be, dm_wdata); else n_pass++;
    n_checks++; if (rdata !== 64'h0) $display("FAIL rst_rdata: got %h want 0", rdata); else n_pass++;
    n_checks++; if ({done, misal, stall} !== 3'b000) $display("FAIL rst_flags: got done=%b mis=%b stall=%b want 0", done, misal, stall); else n_pass++;
    @(negedge clk); rst = 1'b0;
    m_rdata = '0;
  endtask

  task automatic test_ld_latency;
    run_op(1'b0, 3'b011, 64'h1000, '0, 64'h1122334455667788, 3, -1, 7);
    m_rdata = 64'h1122334455667788;
    n_checks++; if (ob_stall !== 4) $display("FAIL ld_stall: got %0d want 4", ob_stall); else n_pass++;
    n_checks++; if (ob_done !== 1) $display("FAIL ld_done: got %0d want 1", ob_done); else n_pass++;
    n_checks++; if (ob_busy !== 3) $display("FAIL ld_req_cycles: got %0d want 3", ob_busy); else n_pass++;
    n_checks++; if (ob_unstable !== 1'b0) $display("FAIL ld_req_stable: got %b want 0", ob_unstable); else n_pass++;
    n_checks++; if ({ob_we, ob_addr, ob_be} !== {1'b0, 64'h1000, 8'hFF}) $display("FAIL ld_req_fields: got we=%b a=%h be=%h want 0/1000/ff", ob_we, ob_addr, ob_be); else n_pass++;
    n_checks++; if (rdata !== 64'h1122334455667788) $display("FAIL ld_rdata: got %h want 1122334455667788", rdata); else n_pass++;
  endtask

  task automatic test_lb_lbu;
    run_op(1'b0, 3'b000, 64'h1003, '0, 64'h0000000080000000, 1, -1, 4);
    n_checks++; if (rdata !== 64'hFFFFFFFFFFFFFF80) $display("FAIL lb_sext: got %h want ffffffffffffff80", rdata); else n_pass++;
    n_checks++; if (ob_be !== 8'h08) $display("FAIL lb_be: got %h want 08", ob_be); else n_pass++;
    run_op(1'b0, 3'b100, 64'h1003, '0, 64'h0000000080000000, 1, -1, 4);
    m_rdata = 64'h80;
    n_checks++; if (rdata !== 64'h80) $display("FAIL lbu_zext: got %h want 80", rdata); else n_pass++;
  endtask

  task automatic test_sh;
    run_op(1'b1, 3'b001, 64'h2006, 64'h0000_0000_0000_ABCD, '0, 1, -1, 4);
    n_checks++; if (ob_be !== 8'hC0) $display("FAIL sh_be: got %h want c0", ob_be); else n_pass++;
    n_checks++; if (ob_wdata[63:48] !== 16'hABCD) $display("FAIL sh_wdata: got %h want abcd", ob_wdata[63:48]); else n_pass++;
    n_checks++; if ({ob_we, ob_addr} !== {1'b1, 64'h2000}) $display("FAIL sh_we_addr: got we=%b a=%h want 1/2000", ob_we, ob_addr); else n_pass++;
    n_checks++; if (rdata !== m_rdata) $display("FAIL sh_rdata_kept: got %h want %h", rdata, m_rdata); else n_pass++;
  endtask

  task automatic test_flush;
    run_op(1'b0, 3'b010, 64'h4000, '0, 64'hDEADBEEF_CAFEF00D, 3, 1, 7);
    n_checks++; if (ob_busy !== 3) $display("FAIL flush_req_held: got %0d want 3", ob_busy); else n_pass++;
    n_checks++; if (ob_done !== 0) $display("FAIL flush_no_done: got %0d want 0", ob_done); else n_pass++;
    n_checks++; if (rdata !== m_rdata) $display("FAIL flush_rdata_kept: got %h want %h", rdata, m_rdata); else n_pass++;
    n_checks++; if (ob_stall !== 4) $display("FAIL flush_stall: got %0d want 4", ob_stall); else n_pass++;
  endtask

  task automatic test_illegal;
    run_op(1'b0, 3'b111, 64'h5000, '0, 64'h1234, 1, -1, 4);
    m_rdata = '0;
    n_checks++; if ({ob_busy, ob_stall} !== {32'd0, 32'd0}) $display("FAIL ill_no_req: got req=%0d stall=%0d want 0/0", ob_busy, ob_stall); else n_pass++;
    n_checks++; if (ob_done !== 1) $display("FAIL ill_done: got %0d want 1", ob_done); else n_pass++;
    n_checks++; if (rdata !== 64'h0) $display("FAIL ill_rdata: got %h want 0", rdata); else n_pass++;
  endtask

  task automatic test_misalign;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
    run_op(1'b0, 3'b010, 64'h3002, '0, 64'h55, 1, -1, 4);
    n_checks++; if (ob_mis !== 1) $display("FAIL mis_pulse: got %0d want 1", ob_mis); else n_pass++;
    n_checks++; if ({ob_busy, ob_stall, ob_done} !== {32'd0, 32'd0, 32'd0}) $display("FAIL mis_quiet: got req=%0d stall=%0d done=%0d want 0", ob_busy, ob_stall, ob_done); else n_pass++;
`else
    run_op(1'b0, 3'b010, 64'h3002, '0, 64'h89ABCDEF_F0E0D0C0, 1, -1, 4);
    m_rdata = m_load(3'b010, 64'h3002, 64'h89ABCDEF_F0E0D0C0);
    n_checks++; if (ob_mis !== 0) $display("FAIL mis_tied: got %0d want 0", ob_mis); else n_pass++;
    n_checks++; if ({ob_addr, ob_be} !== {64'h3000, 8'h0F}) $display("FAIL mis_trunc: got a=%h be=%h want 3000/0f", ob_addr, ob_be); else n_pass++;
    n_checks++; if (rdata !== m_rdata) $display("FAIL mis_rdata: got %h want %h", rdata, m_rdata); else n_pass++;
`endif
  endtask

  task automatic test_reset_busy;
    @(negedge clk);
    valid = 1'b1; we = 1'b0; f3 = 3'b011; addr = 64'h6000; ack = 1'b0; flush = 1'b0;
    @(negedge clk);
    valid = 1'b0; #1;
    n_checks++; if (dm_req !== 1'b1) $display("FAIL rstb_req_before: got %b want 1", dm_req); else n_pass++;
    rst = 1'b1;
    @(negedge clk); #1;
    n_checks++; if ({dm_req, stall} !== 2'b00) $display("FAIL rstb_idle: got req=%b stall=%b want 0/0", dm_req, stall); else n_pass++;
    rst = 1'b0; m_rdata = '0;
    @(negedge clk); #1;
    n_checks++; if ({dm_req, done, rdata} !== {2'b00, 64'h0}) $display("FAIL rstb_after: got req=%b done=%b rd=%h want 0", dm_req, done, rdata); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [63:0] r_addr, r_wd, r_rd;
    int          r_ack;
    for (int k = 0; k < 40; k++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_f3   = r_we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
      r_addr = {$urandom(), $urandom()};
      r_addr[2:0] = 3'(m_off(r_f3, r_addr));
      r_wd   = {$urandom(), $urandom()};
      r_rd   = {$urandom(), $urandom()};
      r_ack  = int'($urandom_range(1, 3));
      run_op(r_we, r_f3, r_addr, r_wd, r_rd, r_ack, -1, r_ack + 2);
      if (!r_we) m_rdata = m_load(r_f3, r_addr, r_rd);
      n_checks++; if ({ob_done, ob_stall} !== {32'd1, 32'(r_ack + 1)}) $display("FAIL b2b_timing[%0d]: got done=%0d stall=%0d want 1/%0d", k, ob_done, ob_stall, r_ack + 1); else n_pass++;
      n_checks++; if ({ob_we, ob_addr, ob_unstable} !== {r_we, r_addr[63:3], 3'b000, 1'b0}) $display("FAIL b2b_req[%0d]: got we=%b a=%h unst=%b want %b/%h", k, ob_we, ob_addr, ob_unstable, r_we, {r_addr[63:3], 3'b000}); else n_pass++;
      n_checks++; if (rdata !== m_rdata) $display("FAIL b2b_rdata[%0d]: got %h want %h", k, rdata, m_rdata); else n_pass++;
      if (r_we) begin
        n_checks++; if (ob_be !== m_be(r_f3, r_addr)) $display("FAIL b2b_be[%0d]: got %h want %h", k, ob_be, m_be(r_f3, r_addr)); else n_pass++;
        n_checks++; if ((ob_wdata & m_lane_mask(r_f3, r_addr)) !== m_lane_data(r_f3, r_addr, r_wd)) $display("FAIL b2b_wdata[%0d]: got %h want %h", k, ob_wdata & m_lane_mask(r_f3, r_addr), m_lane_data(r_f3, r_addr, r_wd)); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_ld_latency();
    test_lb_lbu();
    test_sh();
    test_flush();
    test_illegal();
    test_misalign();
    test_reset_busy();
    test_back_to_back();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
